// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the imem boot loader: image geometry, flash timing default,
// FSM state encoding and the wait-counter sizing helper.
package imem_boot_loader_pkg;

    localparam int IMEM_WORDS   = 2048;
    localparam int IMEM_AW      = 11;
    localparam int DEF_WAIT_CYC = 3;
    localparam int FLASH_AW     = 26;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_LO  = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_SET_HI  = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    // Counter must hold WAIT_CYC-1; keep at least one bit when WAIT_CYC is 1.
    function automatic int cnt_width(input int wait_cyc);
        return (wait_cyc > 1) ? $clog2(wait_cyc) : 1;
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Flash read bus plus imem write port driven by the boot loader (master) and
// served by the flash device / instruction memory (slave).
interface imem_boot_loader_if
    import imem_boot_loader_pkg::*;
#(
    parameter int AW = IMEM_AW
);
    logic [FLASH_AW-1:0] MemAdr;
    logic [15:0]         MemDB;
    logic                flash_oe_n;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [31:0]         wr_data;

    modport master (
        output MemAdr, flash_oe_n, wr_en, wr_addr, wr_data,
        input  MemDB
    );

    modport slave (
        input  MemAdr, flash_oe_n, wr_en, wr_addr, wr_data,
        output MemDB
    );
endinterface

// File: rtl/imem_boot_loader_flash_hw_reader.sv
// Single halfword flash read: latches the address on req, waits WAIT_CYC cycles,
// then raises ack for one cycle while data carries the flash bus value.
module flash_hw_reader
    import imem_boot_loader_pkg::*;
#(
    parameter int                  WAIT_CYC   = DEF_WAIT_CYC,
    parameter logic [FLASH_AW-1:0] RESET_ADDR = '0
) (
    input  logic                clk125,
    input  logic                clrn,
    input  logic                req,
    input  logic [FLASH_AW-1:0] addr,
    output logic [FLASH_AW-1:0] mem_adr,
    input  logic [15:0]         mem_db,
    output logic [15:0]         data,
    output logic                ack
);
    localparam int            CW       = cnt_width(WAIT_CYC);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);

    logic [CW-1:0] cnt;
    logic          active;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk125 or negedge clrn) begin
        if (!clrn) begin
            mem_adr <= RESET_ADDR;
            cnt     <= '0;
            active  <= 1'b0;
        end else if (req) begin
            mem_adr <= addr;
            cnt     <= CNT_LOAD;
            active  <= 1'b1;
        end else if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - 1'b1;
        end
    end

    // Ack lands in the WAIT_CYC-th cycle after the address change, when MemDB is valid.
    assign ack  = active && (cnt == '0);
    assign data = mem_db;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time flash-to-imem copier; holds the CPU in reset until the image is loaded.
// Optional BOOT_CHECKSUM_EN adds a running 32-bit sum of the written words.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int                  WORDS      = IMEM_WORDS,
    parameter int                  AW         = IMEM_AW,
    parameter int                  WAIT_CYC   = DEF_WAIT_CYC,
    parameter logic [FLASH_AW-1:0] FLASH_BASE = '0
) (
    input  logic                clk125,
    input  logic                clrn,
    input  logic                start,
    imem_boot_loader_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                cpu_resetn,
    output logic [31:0]         checksum
);
    localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

    state_e              state;
    logic [AW-1:0]       idx;
    logic [15:0]         lo;
    logic                start_d;
    logic                start_rise;
    logic                rd_req;
    logic                rd_ack;
    logic [15:0]         rd_data;
    logic [FLASH_AW-1:0] rd_addr;
    logic [FLASH_AW-1:0] mem_adr;
    logic                oe_n_q;
    logic                wr_en_q;
    logic [AW-1:0]       wr_addr_q;
    logic [31:0]         wr_data_q;

    assign start_rise = start & ~start_d;
    assign rd_req     = (state == ST_SET_LO) || (state == ST_SET_HI);
    // Halfword address wraps modulo 2^26 by construction of the 26-bit sum.
    assign rd_addr    = FLASH_BASE + (FLASH_AW'(idx) << 1) + FLASH_AW'(state == ST_SET_HI);

    flash_hw_reader #(
        .WAIT_CYC   (WAIT_CYC),
        .RESET_ADDR (FLASH_BASE)
    ) u_reader (
        .clk125  (clk125),
        .clrn    (clrn),
        .req     (rd_req),
        .addr    (rd_addr),
        .mem_adr (mem_adr),
        .mem_db  (bus.MemDB),
        .data    (rd_data),
        .ack     (rd_ack)
    );

    always_ff @(posedge clk125 or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            lo        <= '0;
            start_d   <= 1'b0;
            oe_n_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_d <= start;
            wr_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy  <= 1'b1;
                    idx   <= '0;
                    state <= ST_SET_LO;
                end
                ST_SET_LO: begin
                    oe_n_q <= 1'b0;
                    state  <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (rd_ack) begin
                        lo    <= rd_data;
                        state <= ST_SET_HI;
                    end
                end
                ST_SET_HI: state <= ST_WAIT_HI;
                ST_WAIT_HI: begin
                    // Strobe is raised on entry so it is high exactly for the WRITE cycle.
                    if (rd_ack) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx;
                        wr_data_q <= {rd_data, lo};
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (idx == LAST_IDX) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        oe_n_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_SET_LO;
                    end
                end
                ST_DONE: begin
                    if (start_rise) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        idx   <= '0;
                        state <= ST_SET_LO;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum;
    logic        load_start;

    assign load_start = (state == ST_IDLE) || ((state == ST_DONE) && start_rise);

    always_ff @(posedge clk125 or negedge clrn) begin
        if (!clrn)                  sum <= '0;
        else if (load_start)        sum <= '0;
        else if (state == ST_WRITE) sum <= sum + wr_data_q;
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

    assign cpu_resetn     = done;
    assign bus.MemAdr     = mem_adr;
    assign bus.flash_oe_n = oe_n_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a 4-word image at flash base 0 plus a second
// instance whose base sits at the top of the 26-bit space to exercise the wrap.
module tb_imem_boot_loader;
    localparam int W = 3;

`ifdef BOOT_CHECKSUM_EN
    localparam logic [31:0] CKS0 = 32'h968E9690;
    localparam logic [31:0] CKS1 = 32'h4B464B48;
`else
    localparam logic [31:0] CKS0 = 32'h0;
    localparam logic [31:0] CKS1 = 32'h0;
`endif

    logic [31:0] exp0 [4] = '{32'hA5A4A5A5, 32'hA5A6A5A7, 32'hA5A0A5A1, 32'hA5A2A5A3};
    logic [31:0] exp1 [4] = '{32'h5A5A5A5B, 32'hA5A4A5A5, 32'hA5A6A5A7, 32'hA5A0A5A1};
    logic [25:0] adr1 [8] = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0, 26'h1, 26'h2, 26'h3, 26'h4, 26'h5};

    logic clk125 = 1'b0;
    logic clrn   = 1'b0;
    logic start  = 1'b0;
    logic busy0, done0, rstn0, busy1, done1, rstn1;
    logic [31:0] cks0, cks1;

    int vectors = 0;
    int miscompares = 0;

    imem_boot_loader_if #(.AW(2)) bus0 ();
    imem_boot_loader_if #(.AW(2)) bus1 ();

    imem_boot_loader #(.WORDS(4), .AW(2), .WAIT_CYC(W), .FLASH_BASE(26'h0)) dut0 (
        .clk125(clk125), .clrn(clrn), .start(start), .bus(bus0),
        .busy(busy0), .done(done0), .cpu_resetn(rstn0), .checksum(cks0)
    );

    imem_boot_loader #(.WORDS(4), .AW(2), .WAIT_CYC(W), .FLASH_BASE(26'h3FFFFFE)) dut1 (
        .clk125(clk125), .clrn(clrn), .start(start), .bus(bus1),
        .busy(busy1), .done(done1), .cpu_resetn(rstn1), .checksum(cks1)
    );

    always #4 clk125 = ~clk125;

    // Flash model: data valid only in cycle W after an address change or OE assertion.
    int          age0 = 0, age1 = 0;
    logic [25:0] last0 = '0, last1 = '0;
    logic        loe0 = 1'b1, loe1 = 1'b1;
    logic [25:0] adr_q1 [$];
    logic [1:0]  wa0 [$];
    logic [31:0] wd0 [$], wd1 [$];
    int          xs = 0;

    initial begin
        bus0.MemDB = 16'hxxxx;
        bus1.MemDB = 16'hxxxx;
    end

    always @(posedge clk125) begin
        #1;
        if (bus0.flash_oe_n) age0 = 0;
        else if (loe0 || bus0.MemAdr !== last0) age0 = 1;
        else age0 = age0 + 1;
        last0 = bus0.MemAdr;
        loe0  = bus0.flash_oe_n;
        bus0.MemDB = (age0 == W) ? (bus0.MemAdr[15:0] ^ 16'hA5A5) : 16'hxxxx;

        if (bus1.flash_oe_n) age1 = 0;
        else if (loe1 || bus1.MemAdr !== last1) age1 = 1;
        else age1 = age1 + 1;
        last1 = bus1.MemAdr;
        loe1  = bus1.flash_oe_n;
        if (age1 == 1) adr_q1.push_back(bus1.MemAdr);
        bus1.MemDB = (age1 == W) ? (bus1.MemAdr[15:0] ^ 16'hA5A5) : 16'hxxxx;
    end

    always @(negedge clk125) begin
        if (bus0.wr_en === 1'b1) begin
            wa0.push_back(bus0.wr_addr);
            wd0.push_back(bus0.wr_data);
            if ($isunknown(bus0.wr_data)) xs++;
        end
        if (bus1.wr_en === 1'b1) begin
            wd1.push_back(bus1.wr_data);
            if ($isunknown(bus1.wr_data)) xs++;
        end
    end

    task automatic clear_logs();
        wa0.delete();
        wd0.delete();
        wd1.delete();
        adr_q1.delete();
        xs = 0;
    endtask

    task automatic test_reset();
        clrn  = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk125);
        vectors++; if (bus0.MemAdr !== 26'h0) begin miscompares++; $display("FAIL rst_memadr0 got %h exp %h", bus0.MemAdr, 26'h0); end
        vectors++; if (bus1.MemAdr !== 26'h3FFFFFE) begin miscompares++; $display("FAIL rst_memadr1 got %h exp %h", bus1.MemAdr, 26'h3FFFFFE); end
        vectors++; if (bus0.flash_oe_n !== 1'b1) begin miscompares++; $display("FAIL rst_oe_n got %b exp 1", bus0.flash_oe_n); end
        vectors++; if (bus0.wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en got %b exp 0", bus0.wr_en); end
        vectors++; if (bus0.wr_addr !== 2'd0) begin miscompares++; $display("FAIL rst_wr_addr got %h exp 0", bus0.wr_addr); end
        vectors++; if (bus0.wr_data !== 32'h0) begin miscompares++; $display("FAIL rst_wr_data got %h exp 0", bus0.wr_data); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b exp 0", done0); end
        vectors++; if (rstn0 !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_resetn got %b exp 0", rstn0); end
        vectors++; if (cks0 !== 32'h0) begin miscompares++; $display("FAIL rst_checksum got %h exp 0", cks0); end
    endtask

    // Boot with start held high through reset release: exactly one load, 37 cycles.
    task automatic test_boot();
        clear_logs();
        clrn = 1'b1;
        for (int c = 1; c <= 37; c++) begin
            @(posedge clk125);
            #1;
            if (c == 1) begin
                vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL boot_busy got %b exp 1", busy0); end
            end
            if (c == 36) begin
                vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL boot_done_early got %b exp 0", done0); end
                vectors++; if (rstn0 !== 1'b0) begin miscompares++; $display("FAIL boot_cpu_rst_early got %b exp 0", rstn0); end
            end
            if (c == 37) begin
                vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL boot_done got %b exp 1", done0); end
                vectors++; if (rstn0 !== 1'b1) begin miscompares++; $display("FAIL boot_cpu_resetn got %b exp 1", rstn0); end
                vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL boot_busy_end got %b exp 0", busy0); end
                vectors++; if (bus0.flash_oe_n !== 1'b1) begin miscompares++; $display("FAIL boot_oe_n_end got %b exp 1", bus0.flash_oe_n); end
            end
        end
        vectors++; if (wa0.size() != 4) begin miscompares++; $display("FAIL boot_wr_count got %0d exp 4", wa0.size()); end
        if (wa0.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (wa0[i] !== 2'(i)) begin miscompares++; $display("FAIL boot_wr_addr[%0d] got %h exp %h", i, wa0[i], 2'(i)); end
                vectors++; if (wd0[i] !== exp0[i]) begin miscompares++; $display("FAIL boot_wr_data[%0d] got %h exp %h", i, wd0[i], exp0[i]); end
            end
        end
        vectors++; if (cks0 !== CKS0) begin miscompares++; $display("FAIL boot_checksum got %h exp %h", cks0, CKS0); end
        vectors++; if (xs != 0) begin miscompares++; $display("FAIL boot_wr_data_x got %0d exp 0", xs); end
        // Wrap instance: address sequence, data and checksum.
        vectors++; if (adr_q1.size() != 8) begin miscompares++; $display("FAIL wrap_adr_count got %0d exp 8", adr_q1.size()); end
        if (adr_q1.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                vectors++; if (adr_q1[i] !== adr1[i]) begin miscompares++; $display("FAIL wrap_adr[%0d] got %h exp %h", i, adr_q1[i], adr1[i]); end
            end
        end
        vectors++; if (wd1.size() != 4) begin miscompares++; $display("FAIL wrap_wr_count got %0d exp 4", wd1.size()); end
        if (wd1.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (wd1[i] !== exp1[i]) begin miscompares++; $display("FAIL wrap_wr_data[%0d] got %h exp %h", i, wd1[i], exp1[i]); end
            end
        end
        vectors++; if (cks1 !== CKS1) begin miscompares++; $display("FAIL wrap_checksum got %h exp %h", cks1, CKS1); end
        repeat (20) @(negedge clk125);
        vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL boot_no_reload_done got %b exp 1", done0); end
        vectors++; if (wa0.size() != 4) begin miscompares++; $display("FAIL boot_no_reload_count got %0d exp 4", wa0.size()); end
        start = 1'b0;
        @(negedge clk125);
    endtask

    task automatic test_start_busy();
        int n;
        clear_logs();
        start = 1'b1;
        @(negedge clk125);
        vectors++; if (rstn0 !== 1'b0) begin miscompares++; $display("FAIL restart_cpu_resetn got %b exp 0", rstn0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL restart_done got %b exp 0", done0); end
        vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL restart_busy got %b exp 1", busy0); end
        start = 1'b0;
        repeat (10) @(negedge clk125);
        start = 1'b1;
        @(negedge clk125);
        start = 1'b0;
        n = 0;
        while (done0 !== 1'b1 && n < 100) begin @(negedge clk125); n++; end
        vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL restart_timeout done got %b exp 1", done0); end
        vectors++; if (wa0.size() != 4) begin miscompares++; $display("FAIL busy_pulse_count got %0d exp 4", wa0.size()); end
        if (wa0.size() == 4) begin
            vectors++; if (wd0[3] !== exp0[3]) begin miscompares++; $display("FAIL restart_word3 got %h exp %h", wd0[3], exp0[3]); end
        end
        vectors++; if (cks0 !== CKS0) begin miscompares++; $display("FAIL restart_checksum got %h exp %h", cks0, CKS0); end
        repeat (15) @(negedge clk125);
        vectors++; if (wa0.size() != 4) begin miscompares++; $display("FAIL busy_pulse_late_count got %0d exp 4", wa0.size()); end
        // Held start: one reload only.
        clear_logs();
        start = 1'b1;
        repeat (100) @(negedge clk125);
        vectors++; if (wa0.size() != 4) begin miscompares++; $display("FAIL held_start_count got %0d exp 4", wa0.size()); end
        vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL held_start_done got %b exp 1", done0); end
        start = 1'b0;
        @(negedge clk125);
    endtask

    task automatic test_abort();
        int n;
        clear_logs();
        start = 1'b1;
        @(posedge clk125);
        repeat (24) @(posedge clk125);
        #2;
        clrn = 1'b0;
        #1;
        vectors++; if (wa0.size() != 2) begin miscompares++; $display("FAIL abort_words_before got %0d exp 2", wa0.size()); end
        vectors++; if (bus0.MemAdr !== 26'h0) begin miscompares++; $display("FAIL abort_memadr got %h exp 0", bus0.MemAdr); end
        vectors++; if (bus0.flash_oe_n !== 1'b1) begin miscompares++; $display("FAIL abort_oe_n got %b exp 1", bus0.flash_oe_n); end
        vectors++; if (bus0.wr_en !== 1'b0) begin miscompares++; $display("FAIL abort_wr_en got %b exp 0", bus0.wr_en); end
        vectors++; if (bus0.wr_addr !== 2'd0) begin miscompares++; $display("FAIL abort_wr_addr got %h exp 0", bus0.wr_addr); end
        vectors++; if (bus0.wr_data !== 32'h0) begin miscompares++; $display("FAIL abort_wr_data got %h exp 0", bus0.wr_data); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b exp 0", busy0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b exp 0", done0); end
        vectors++; if (rstn0 !== 1'b0) begin miscompares++; $display("FAIL abort_cpu_resetn got %b exp 0", rstn0); end
        vectors++; if (cks0 !== 32'h0) begin miscompares++; $display("FAIL abort_checksum got %h exp 0", cks0); end
        start = 1'b0;
        repeat (3) @(negedge clk125);
        clear_logs();
        clrn = 1'b1;
        n = 0;
        while (done0 !== 1'b1 && n < 60) begin @(negedge clk125); n++; end
        vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL reload_timeout done got %b exp 1", done0); end
        vectors++; if (wa0.size() != 4) begin miscompares++; $display("FAIL reload_count got %0d exp 4", wa0.size()); end
        if (wa0.size() == 4) begin
            vectors++; if (wa0[0] !== 2'd0) begin miscompares++; $display("FAIL reload_first_addr got %h exp 0", wa0[0]); end
            vectors++; if (wd0[0] !== 32'hA5A4A5A5) begin miscompares++; $display("FAIL reload_word0 got %h exp %h", wd0[0], 32'hA5A4A5A5); end
        end
        vectors++; if (xs != 0) begin miscompares++; $display("FAIL reload_wr_data_x got %0d exp 0", xs); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_start_busy();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
